// File: rtl/fb_sprite_blitter.sv
// Copies a sprite from SRAM into the 320x240 video buffer, one pixel per clock, skipping KEY_COLOR and clipping at the edges.
// Latency: w*h+2 cycles after start (1 for empty or offscreen). There is no backpressure; start is ignored while busy.
module fb_sprite_blitter #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 18,
  parameter int VBUF_W = 320,
  parameter int VBUF_H = 240,
  parameter logic [DATA_WIDTH-1:0] KEY_COLOR = 12'h0F0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [6:0]            spr_w,
  input  logic [5:0]            spr_h,
  input  logic [8:0]            dst_x,
  input  logic [7:0]            dst_y,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [6:0] w;
  logic [5:0] h;
  logic [9:0] dx;
  logic [8:0] dy;
  logic [6:0] col;
  logic [5:0] row;
  logic [9:0] cur_x;
  logic [8:0] cur_y;
  logic       last_pix;
  logic       empty;

  logic                  p_vld;
  logic                  p_inb;
  logic [ADDR_WIDTH-1:0] p_addr;

  // Widened coordinates: a sprite hanging past the edge can never wrap back on-screen.
  assign cur_x    = dx + {3'b000, col};
  assign cur_y    = dy + {3'b000, row};
  assign last_pix = (col == w - 7'd1) && (row == h - 6'd1);
  assign empty    = (spr_w == 7'd0) || (spr_h == 6'd0) ||
                    ({1'b0, dst_x} >= 10'(VBUF_W)) || ({1'b0, dst_y} >= 9'(VBUF_H));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = empty ? DONE : RUN;
      RUN:     if (last_pix) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w       <= '0;
      h       <= '0;
      dx      <= '0;
      dy      <= '0;
      col     <= '0;
      row     <= '0;
      rd_addr <= '0;
      p_vld   <= 1'b0;
      p_inb   <= 1'b0;
      p_addr  <= '0;
    end else begin
      p_vld <= (state == RUN);
      if (state == IDLE && start) begin
        w       <= spr_w;
        h       <= spr_h;
        dx      <= {1'b0, dst_x};
        dy      <= {1'b0, dst_y};
        col     <= '0;
        row     <= '0;
        rd_addr <= src_base;
      end else if (state == RUN) begin
        // Destination travels one stage behind the read to meet the returning data.
        p_inb   <= (cur_x < 10'(VBUF_W)) && (cur_y < 9'(VBUF_H));
        p_addr  <= ADDR_WIDTH'(cur_y) * ADDR_WIDTH'(VBUF_W) + ADDR_WIDTH'(cur_x);
        rd_addr <= rd_addr + 1'b1;
        if (col == w - 7'd1) begin
          col <= '0;
          row <= row + 6'd1;
        end else begin
          col <= col + 7'd1;
        end
      end
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign rd_en   = (state == RUN);
  assign wr_en   = p_vld && p_inb && (rd_data != KEY_COLOR);
  assign wr_addr = p_addr;
  assign wr_data = rd_data;

endmodule
